// File: rtl/mult_feeder_pkg.sv
// mult_feeder_pkg: shared state encodings and constants for the multiplier operand feeder
package mult_feeder_pkg;
  localparam int L_WORD_DEF = 4;
  localparam int TIMEOUT_DEF = L_WORD_DEF + 2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESULT = 2'd3;
  function automatic int timeout_limit(input int l_word);
    return l_word + 2;
  endfunction
endpackage

// File: rtl/operand_fifo.sv
// operand_fifo: synchronous FIFO of {word1, word2} pairs with wrap-around pointers
module operand_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] data,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, rd_ptr;
  logic [W-1:0] mem [DEPTH];
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head = mem[rd_ptr[AW-1:0]];
  // pointer advance; the extra MSB tells full from empty when the indices match
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  // storage needs no reset since stale entries are masked by empty
  always_ff @(posedge clock)
    if (push && !full) mem[wr_ptr[AW-1:0]] <= data;
endmodule

// File: rtl/mult_operand_feeder.sv
// mult_operand_feeder: queues operand pairs, drives the shift-add multiplier and presents its products
module mult_operand_feeder
  import mult_feeder_pkg::*;
#(
  parameter int L_WORD = L_WORD_DEF,
  parameter int DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [L_WORD-1:0]   in_word1,
  input  logic [L_WORD-1:0]   in_word2,
  output logic                mult_start,
  output logic [L_WORD-1:0]   mult_word1,
  output logic [L_WORD-1:0]   mult_word2,
  input  logic                mult_ready,
  input  logic [2*L_WORD-1:0] mult_product,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [2*L_WORD-1:0] res_product,
  output logic [L_WORD-1:0]   res_word1,
  output logic [L_WORD-1:0]   res_word2,
  output logic                busy,
  output logic                err_timeout
);
  localparam int TMO = timeout_limit(L_WORD);
  localparam int CW = $clog2(L_WORD + 3);
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic full, empty, push, pop, expired, done;
  logic [2*L_WORD-1:0] head;
  assign in_ready = !full;
  assign push = in_valid && !full;
  assign pop = (state == ST_IDLE) && !empty && mult_ready;
  assign expired = cnt == CW'(TMO - 1);
  assign done = mult_ready || expired;
  assign mult_start = state == ST_ISSUE;
  assign res_valid = state == ST_RESULT;
  assign busy = (state != ST_IDLE) || !empty;
  operand_fifo #(.W(2 * L_WORD), .DEPTH(DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(push),
    .pop(pop),
    .data({in_word1, in_word2}),
    .full(full),
    .empty(empty),
    .head(head)
  );
  // sequencer; the WAIT counter bounds how long a hung multiplier can stall the stream
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= ST_IDLE;
      cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (pop) state <= ST_ISSUE;
        ST_ISSUE: begin
          state <= ST_WAIT;
          cnt <= '0;
        end
        ST_WAIT:
          if (done) state <= ST_RESULT;
          else cnt <= cnt + 1'b1;
        ST_RESULT: if (res_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  // operands and their echo load together on pop and hold until the next pop
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      {mult_word1, mult_word2} <= '0;
      {res_word1, res_word2} <= '0;
    end else if (pop) begin
      {mult_word1, mult_word2} <= head;
      {res_word1, res_word2} <= head;
    end
  // product capture on completion or expiry; expiry latches the sticky error
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      res_product <= '0;
      err_timeout <= 1'b0;
    end else if (state == ST_WAIT && done) begin
      res_product <= mult_product;
      if (!mult_ready) err_timeout <= 1'b1;
    end
endmodule
